// File: rtl/pic_cascade_pkg.sv
// Shared types and constants for the 8259A-style cascade slave responder.
// Holds the acknowledge-sequence state encoding and the vector byte builder.
package pic_cascade_pkg;

  localparam int CAS_W = 3;
  localparam logic [2:0] SPURIOUS_IR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    GAP  = 2'd2,
    P2   = 2'd3
  } state_t;

  // With no request pending the slave answers with IR7, the spurious vector.
  function automatic logic [7:0] make_vector(input logic [4:0] base,
                                             input logic       req,
                                             input logic [2:0] level);
    return {base, req ? level : SPURIOUS_IR};
  endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, plus a registered edge detect.
// fall/rise are derived only from flops, so they are clean one-cycle strobes.
module pic_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_d <= RESET_VAL;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      level_d <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign fall  = level_d & ~level;
  assign rise  = ~level_d & level;

endmodule

// File: rtl/pic_cascade_slave_responder.sv
// Slave end of the cascade bus: follows the two-pulse INTA sequence, claims it when
// CAS matches the ICW3 slave ID, and drives the vector byte during the second pulse.
module pic_cascade_slave_responder
  import pic_cascade_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sp_en,
  input  logic [CAS_W-1:0] icw3_id,
  input  logic [CAS_W-1:0] cas_in,
  input  logic             inta_n,
  input  logic             int_req,
  input  logic [2:0]       ir_level,
  input  logic [4:0]       vector_base,
  output logic             selected,
  output logic             isr_set,
  output logic [7:0]       data_out,
  output logic             data_oe,
  output logic             seq_done,
  output logic             timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             selected_n, isr_set_n, data_oe_n, seq_done_n, timeout_err_n;
  logic [7:0]       data_out_n;
  logic             claim;

  logic             inta_s, inta_fall, inta_rise;
  logic [CAS_W-1:0] cas_sync [SYNC_STAGES];
  logic [CAS_W-1:0] cas_s;

  pic_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_inta_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (inta_n),
    .level(inta_s),
    .fall (inta_fall),
    .rise (inta_rise)
  );

  // Same depth as the INTA path so CAS is seen aligned with the pulse-1 fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) cas_sync[i] <= '0;
    end else begin
      cas_sync[0] <= cas_in;
      for (int i = 1; i < SYNC_STAGES; i++) cas_sync[i] <= cas_sync[i-1];
    end
  end

  assign cas_s = cas_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      selected    <= 1'b0;
      isr_set     <= 1'b0;
      data_out    <= 8'h00;
      data_oe     <= 1'b0;
      seq_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      selected    <= selected_n;
      isr_set     <= isr_set_n;
      data_out    <= data_out_n;
      data_oe     <= data_oe_n;
      seq_done    <= seq_done_n;
      timeout_err <= timeout_err_n;
    end
  end

  // The FSM steps through every sequence, claimed or not, to stay in step with the master.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    selected_n    = selected;
    isr_set_n     = 1'b0;
    data_out_n    = data_out;
    data_oe_n     = data_oe;
    seq_done_n    = 1'b0;
    timeout_err_n = 1'b0;
    claim         = ~sp_en & (cas_s == icw3_id);

    case (state)
      IDLE: begin
        if (inta_fall) begin
          state_n    = P1;
          selected_n = claim;
          isr_set_n  = claim & int_req;
          if (claim) data_out_n = make_vector(vector_base, int_req, ir_level);
        end
      end
      P1: begin
        if (inta_rise) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (inta_fall) begin
          state_n   = P2;
          data_oe_n = selected;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          state_n       = IDLE;
          timeout_err_n = 1'b1;
          selected_n    = 1'b0;
          data_out_n    = 8'h00;
          cnt_n         = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      P2: begin
        if (inta_rise) begin
          state_n    = IDLE;
          data_oe_n  = 1'b0;
          selected_n = 1'b0;
          seq_done_n = 1'b1;
          data_out_n = 8'h00;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pic_cascade_slave_responder.sv
// Bench for the cascade slave responder: directed and randomized INTA sequences
// checked against a pin-level model of claim, vector and strobe behaviour.
module tb_pic_cascade_slave_responder;
  import pic_cascade_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 64;
  localparam int LAT  = SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sp_en = 1'b0;
  logic [2:0] icw3_id = '0;
  logic [2:0] cas_in = '0;
  logic       inta_n = 1'b1;
  logic       int_req = 1'b0;
  logic [2:0] ir_level = '0;
  logic [4:0] vector_base = '0;
  logic       selected, isr_set, data_oe, seq_done, timeout_err;
  logic [7:0] data_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  int isr_tot = 0, done_tot = 0, to_tot = 0, oe_tot = 0;
  logic [7:0] oe_val = '0;

  pic_cascade_slave_responder #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sp_en      (sp_en),
    .icw3_id    (icw3_id),
    .cas_in     (cas_in),
    .inta_n     (inta_n),
    .int_req    (int_req),
    .ir_level   (ir_level),
    .vector_base(vector_base),
    .selected   (selected),
    .isr_set    (isr_set),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .seq_done   (seq_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (isr_set)     isr_tot  <= isr_tot + 1;
    if (seq_done)    done_tot <= done_tot + 1;
    if (timeout_err) to_tot   <= to_tot + 1;
    if (data_oe) begin
      oe_tot <= oe_tot + 1;
      oe_val <= data_out;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({selected, isr_set, data_oe, seq_done, timeout_err, data_out} !== 13'h0)
      $display("FAIL reset_outputs: got sel=%b isr=%b oe=%b done=%b to=%b dout=%h, want all 0",
               selected, isr_set, data_oe, seq_done, timeout_err, data_out);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state);
    else pass_cnt++;
  endtask

  // One complete two-pulse sequence; expectations come from the claim/vector rules.
  task automatic run_seq(input string name, input bit sp, input logic [2:0] id,
                         input logic [2:0] cas, input bit req, input logic [2:0] lvl,
                         input logic [4:0] base, input bit scramble);
    int w1, g, w2, isr0, done0, to0, oe0;
    bit claim;
    logic [7:0] vec;
    claim = (sp == 1'b0) && (cas == id);
    vec   = claim ? {base, (req ? lvl : 3'd7)} : 8'h00;
    w1 = $urandom_range(3, 6);
    g  = $urandom_range(4, 10);
    w2 = $urandom_range(3, 6);
    isr0 = isr_tot; done0 = done_tot; to0 = to_tot; oe0 = oe_tot;

    sp_en = sp; icw3_id = id; cas_in = cas; int_req = req; ir_level = lvl; vector_base = base;
    inta_n = 1'b0;
    repeat (w1) @(negedge clk);
    if (scramble) begin
      sp_en = 1'($urandom); icw3_id = 3'($urandom); cas_in = 3'($urandom);
      int_req = 1'($urandom); ir_level = 3'($urandom); vector_base = 5'($urandom);
    end
    inta_n = 1'b1;
    repeat (g) @(negedge clk);
    total_cnt++;
    if (selected !== claim) $display("FAIL %s_selected: got %b want %b", name, selected, claim);
    else pass_cnt++;
    total_cnt++;
    if (data_out !== vec) $display("FAIL %s_latched_vec: got %h want %h", name, data_out, vec);
    else pass_cnt++;
    total_cnt++;
    if (data_oe !== 1'b0) $display("FAIL %s_oe_in_gap: got %b want 0", name, data_oe);
    else pass_cnt++;
    inta_n = 1'b0;
    repeat (w2) @(negedge clk);
    inta_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);

    total_cnt++;
    if (isr_tot - isr0 !== int'(claim && req))
      $display("FAIL %s_isr_pulses: got %0d want %0d", name, isr_tot - isr0, int'(claim && req));
    else pass_cnt++;
    total_cnt++;
    if (oe_tot - oe0 !== (claim ? w2 : 0))
      $display("FAIL %s_oe_cycles: got %0d want %0d", name, oe_tot - oe0, claim ? w2 : 0);
    else pass_cnt++;
    if (claim) begin
      total_cnt++;
      if (oe_val !== vec) $display("FAIL %s_bus_vec: got %h want %h", name, oe_val, vec);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_tot - done0 !== 1) $display("FAIL %s_seq_done: got %0d want 1", name, done_tot - done0);
    else pass_cnt++;
    total_cnt++;
    if (to_tot - to0 !== 0) $display("FAIL %s_no_timeout: got %0d want 0", name, to_tot - to0);
    else pass_cnt++;
    total_cnt++;
    if ({selected, data_oe, data_out} !== 10'h0 || dut.state !== IDLE)
      $display("FAIL %s_end_idle: got sel=%b oe=%b dout=%h st=%0d want 0/0/00/IDLE",
               name, selected, data_oe, data_out, dut.state);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    run_seq("claim_ir5", 1'b0, 3'b110, 3'b110, 1'b1, 3'd5, 5'b01000, 1'b0);
    run_seq("no_match", 1'b0, 3'b110, 3'b010, 1'b1, 3'd2, 5'b10101, 1'b0);
    run_seq("spurious", 1'b0, 3'b111, 3'b111, 1'b0, 3'd3, 5'b01000, 1'b0);
    run_seq("master_mode", 1'b1, 3'b000, 3'b000, 1'b1, 3'd1, 5'b11111, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] id;
    for (int i = 0; i < 20; i++) begin
      id = 3'($urandom);
      run_seq("random", ($urandom_range(0, 3) == 0), id,
              ($urandom_range(0, 1) == 1) ? id : 3'($urandom),
              1'($urandom), 3'($urandom), 5'($urandom), 1'b1);
    end
  endtask

  task automatic test_timeout();
    int first, hits, to0;
    first = -1; hits = 0; to0 = to_tot;
    sp_en = 1'b0; icw3_id = 3'd3; cas_in = 3'd3; int_req = 1'b1; ir_level = 3'd2; vector_base = 5'd9;
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    inta_n = 1'b1;
    for (int k = 1; k <= LAT + TMO + 5; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        hits++;
        if (first < 0) first = k;
      end
    end
    total_cnt++;
    if (first !== LAT + TMO + 1)
      $display("FAIL timeout_cycle: got %0d want %0d", first, LAT + TMO + 1);
    else pass_cnt++;
    total_cnt++;
    if (hits !== 1) $display("FAIL timeout_width: got %0d want 1", hits);
    else pass_cnt++;
    total_cnt++;
    if ({selected, data_oe, data_out} !== 10'h0 || dut.state !== IDLE)
      $display("FAIL timeout_idle: got sel=%b oe=%b dout=%h st=%0d want 0/0/00/IDLE",
               selected, data_oe, data_out, dut.state);
    else pass_cnt++;
    run_seq("after_timeout", 1'b0, 3'd4, 3'd4, 1'b1, 3'd6, 5'b00110, 1'b0);
  endtask

  // Pulse-2 fall becomes visible in exactly the cycle the counter hits its limit.
  task automatic test_fall_beats_timeout();
    int to0, done0;
    to0 = to_tot; done0 = done_tot;
    sp_en = 1'b0; icw3_id = 3'd1; cas_in = 3'd1; int_req = 1'b1; ir_level = 3'd0; vector_base = 5'd21;
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    inta_n = 1'b1;
    repeat (TMO + 1) @(negedge clk);
    inta_n = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    total_cnt++;
    if (data_oe !== 1'b1 || data_out !== {5'd21, 3'd0})
      $display("FAIL fall_wins_oe: got oe=%b dout=%h want 1/%h", data_oe, data_out, {5'd21, 3'd0});
    else pass_cnt++;
    inta_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    total_cnt++;
    if (to_tot - to0 !== 0 || done_tot - done0 !== 1)
      $display("FAIL fall_wins_strobes: got to=%0d done=%0d want 0/1", to_tot - to0, done_tot - done0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_p2();
    sp_en = 1'b0; icw3_id = 3'd5; cas_in = 3'd5; int_req = 1'b1; ir_level = 3'd7; vector_base = 5'd2;
    inta_n = 1'b0;
    repeat (4) @(negedge clk);
    inta_n = 1'b1;
    repeat (5) @(negedge clk);
    inta_n = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    total_cnt++;
    if (data_oe !== 1'b1) $display("FAIL p2_before_reset: got oe=%b want 1", data_oe);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({selected, data_oe, data_out} !== 10'h0)
      $display("FAIL async_release: got sel=%b oe=%b dout=%h want 0/0/00", selected, data_oe, data_out);
    else pass_cnt++;
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (dut.state !== IDLE || data_oe !== 1'b0)
      $display("FAIL reset_release_idle: got st=%0d oe=%b want IDLE/0", dut.state, data_oe);
    else pass_cnt++;
    run_seq("after_reset", 1'b0, 3'd2, 3'd2, 1'b1, 3'd3, 5'b11000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_fall_beats_timeout();
    test_reset_mid_p2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
